// File: rtl/dwt_level_scheduler_if.sv
// Handshake and control bundle between the DWT level scheduler and its
// neighbours: the sample source, the lifting datapath and the coarse RAM.
// ADDR_W and LVL_W must match the scheduler's N_SAMPLES / LEVELS.
interface dwt_level_scheduler_if #(
    parameter int ADDR_W = 3,
    parameter int LVL_W  = 2
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              iseven;
    logic              even_wr_en;
    logic              even_rd_en;
    logic              valid_detail_out;
    logic [ADDR_W-1:0] detail_idx;
    logic              valid_coarse_out;
    logic              coarse_wr_en;
    logic [ADDR_W-1:0] coarse_wr_addr;
    logic              coarse_rd_en;
    logic [ADDR_W-1:0] coarse_rd_addr;
    logic              wr_bank;
    logic              rd_bank;
    logic              internal_valid;
    logic [LVL_W-1:0]  level;
    logic              busy;
    logic              done;

    // Environment side: drives start/samples, observes strobes.
    modport master (
        output start, in_valid,
        input  in_ready, iseven, even_wr_en, even_rd_en, valid_detail_out,
        input  detail_idx, valid_coarse_out, coarse_wr_en, coarse_wr_addr,
        input  coarse_rd_en, coarse_rd_addr, wr_bank, rd_bank, internal_valid,
        input  level, busy, done
    );

    // Scheduler side.
    modport slave (
        input  start, in_valid,
        output in_ready, iseven, even_wr_en, even_rd_en, valid_detail_out,
        output detail_idx, valid_coarse_out, coarse_wr_en, coarse_wr_addr,
        output coarse_rd_en, coarse_rd_addr, wr_bank, rd_bank, internal_valid,
        output level, busy, done
    );
endinterface

// File: rtl/dwt_level_scheduler.sv
// Multi-level 1-D lifting DWT scheduler. Counts accepted samples per level,
// issues predict (detail) and update (coarse) strobes, writes coarse
// coefficients into a ping-pong buffer and replays them as the next level's
// input. All timing is relative to each accept, so it is data-independent.
module dwt_level_scheduler #(
    parameter int N_SAMPLES = 8,
    parameter int LEVELS    = 2,
    parameter int ADDR_W    = $clog2(N_SAMPLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    dwt_level_scheduler_if.slave bus
);
    localparam int LVL_W = $clog2(LEVELS + 1);
    localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(LEVELS - 1);

    // Reject frame sizes that cannot hold at least one pair at the last level.
    generate
        if ((LEVELS < 1) || (N_SAMPLES < 4) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0)
            || ((N_SAMPLES >> (LEVELS - 1)) < 2)) begin : g_bad_params
            $error("dwt_level_scheduler: illegal N_SAMPLES/LEVELS combination");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_REPLAY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic              in_ready_q, in_ready_d;
    logic              det_valid_q, det_valid_d;
    logic [ADDR_W-1:0] det_idx_q, det_idx_d;
    logic              coarse_valid_q, coarse_valid_d;
    logic [ADDR_W-1:0] coarse_addr_q, coarse_addr_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              int_valid_q, int_valid_d;
    logic              rd_bank_q, rd_bank_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic [ADDR_W-1:0] last_k;     // len-1 for the current level
    logic [ADDR_W-1:0] half_last;  // len/2-1: index of the last pair
    logic              k_is_last;
    logic              last_coarse;

    // Level length is N_SAMPLES>>level; the index wraps naturally at level 0.
    assign last_k      = ADDR_W'((N_SAMPLES >> level_q) - 1);
    assign half_last   = last_k >> 1;
    assign accept      = (in_ready_q && bus.in_valid) || ((state_q == S_REPLAY) && int_valid_q);
    assign k_is_last   = (k_q == last_k);
    assign last_coarse = coarse_valid_q && (coarse_addr_q == half_last);

    // Next-state, counters and registered strobes.
    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        k_d            = k_q;
        rd_en_d        = 1'b0;
        rd_addr_d      = '0;
        int_valid_d    = rd_en_q;
        // Detail for pair m-1 follows an even accept k=2m>=2; the last pair
        // follows the final accept (mirror boundary lives in the datapath).
        det_valid_d    = accept && ((!k_q[0] && (k_q != '0)) || k_is_last);
        det_idx_d      = '0;
        if (det_valid_d) begin
            det_idx_d = k_q[0] ? (k_q >> 1) : ((k_q >> 1) - ADDR_W'(1));
        end
        coarse_valid_d = det_valid_q;
        coarse_addr_d  = det_valid_q ? det_idx_q : '0;

        if (accept) begin
            k_d = k_is_last ? '0 : (k_q + ADDR_W'(1));
        end

        case (state_q)
            S_IDLE: begin
                k_d     = '0;
                level_d = '0;
                if (bus.start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept && k_is_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (last_coarse) begin
                    if (level_q != TOP_LVL) begin
                        state_d   = S_REPLAY;
                        level_d   = level_q + LVL_W'(1);
                        k_d       = '0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REPLAY: begin
                // Read the previous level's coarse outputs back to back; there
                // are exactly as many as the current level's length.
                if (rd_en_q && (rd_addr_q != last_k)) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
                if (accept && k_is_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                level_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        // Read bank is the opposite of the write bank, but held low when idle.
        rd_bank_d  = (state_d != S_IDLE) && !level_d[0];
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            level_q        <= '0;
            k_q            <= '0;
            in_ready_q     <= 1'b0;
            det_valid_q    <= 1'b0;
            det_idx_q      <= '0;
            coarse_valid_q <= 1'b0;
            coarse_addr_q  <= '0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            int_valid_q    <= 1'b0;
            rd_bank_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            k_q            <= k_d;
            in_ready_q     <= in_ready_d;
            det_valid_q    <= det_valid_d;
            det_idx_q      <= det_idx_d;
            coarse_valid_q <= coarse_valid_d;
            coarse_addr_q  <= coarse_addr_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            int_valid_q    <= int_valid_d;
            rd_bank_q      <= rd_bank_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Even-sample strobes are tied to the accept itself, so they are combinational.
    assign bus.iseven           = accept && !k_q[0];
    assign bus.even_wr_en       = accept && !k_q[0];
    assign bus.in_ready         = in_ready_q;
    assign bus.even_rd_en       = det_valid_q;
    assign bus.valid_detail_out = det_valid_q;
    assign bus.detail_idx       = det_idx_q;
    assign bus.valid_coarse_out = coarse_valid_q;
    assign bus.coarse_wr_en     = coarse_valid_q;
    assign bus.coarse_wr_addr   = coarse_addr_q;
    assign bus.coarse_rd_en     = rd_en_q;
    assign bus.coarse_rd_addr   = rd_addr_q;
    assign bus.wr_bank          = level_q[0];
    assign bus.rd_bank          = rd_bank_q;
    assign bus.internal_valid   = int_valid_q;
    assign bus.level            = level_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
endmodule

// File: tb/tb_dwt_level_scheduler.sv
// Bench for dwt_level_scheduler: two instances (N=8, LEVELS=2 and LEVELS=3)
// share one stimulus stream. An event-timing model derives, from the accept
// times of each level, the cycle of every strobe, and every cycle of every
// frame is compared against it.
module tb_dwt_level_scheduler;
    localparam int N    = 8;
    localparam int MAXT = 255;

    logic clk = 1'b0;
    logic reset;
    logic start_r;
    logic in_valid_r;

    always #5 clk = ~clk;

    dwt_level_scheduler_if #(.ADDR_W(3), .LVL_W(2)) if2 ();
    dwt_level_scheduler_if #(.ADDR_W(3), .LVL_W(2)) if3 ();

    assign if2.start    = start_r;
    assign if2.in_valid = in_valid_r;
    assign if3.start    = start_r;
    assign if3.in_valid = in_valid_r;

    dwt_level_scheduler #(.N_SAMPLES(N), .LEVELS(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    dwt_level_scheduler #(.N_SAMPLES(N), .LEVELS(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    // Packed observation: [0] in_ready [1] iseven [2] even_wr_en [3] even_rd_en
    // [4] valid_detail [5] valid_coarse [6] coarse_wr_en [7] coarse_rd_en
    // [8] wr_bank [9] rd_bank [10] internal_valid [11] busy [12] done
    // [15:13] detail_idx [18:16] coarse_wr_addr [21:19] coarse_rd_addr
    // (addresses only meaningful while their strobe is high) [23:22] level
    logic [31:0] obs [2];
    logic [8:0]  raw [2];

    always_comb begin
        obs[0] = '0;
        obs[0][0] = if2.in_ready;         obs[0][1] = if2.iseven;
        obs[0][2] = if2.even_wr_en;       obs[0][3] = if2.even_rd_en;
        obs[0][4] = if2.valid_detail_out; obs[0][5] = if2.valid_coarse_out;
        obs[0][6] = if2.coarse_wr_en;     obs[0][7] = if2.coarse_rd_en;
        obs[0][8] = if2.wr_bank;          obs[0][9] = if2.rd_bank;
        obs[0][10] = if2.internal_valid;  obs[0][11] = if2.busy;
        obs[0][12] = if2.done;
        obs[0][15:13] = if2.valid_detail_out ? if2.detail_idx : 3'd0;
        obs[0][18:16] = if2.valid_coarse_out ? if2.coarse_wr_addr : 3'd0;
        obs[0][21:19] = if2.coarse_rd_en ? if2.coarse_rd_addr : 3'd0;
        obs[0][23:22] = if2.level;
        raw[0] = {if2.detail_idx, if2.coarse_wr_addr, if2.coarse_rd_addr};
    end

    always_comb begin
        obs[1] = '0;
        obs[1][0] = if3.in_ready;         obs[1][1] = if3.iseven;
        obs[1][2] = if3.even_wr_en;       obs[1][3] = if3.even_rd_en;
        obs[1][4] = if3.valid_detail_out; obs[1][5] = if3.valid_coarse_out;
        obs[1][6] = if3.coarse_wr_en;     obs[1][7] = if3.coarse_rd_en;
        obs[1][8] = if3.wr_bank;          obs[1][9] = if3.rd_bank;
        obs[1][10] = if3.internal_valid;  obs[1][11] = if3.busy;
        obs[1][12] = if3.done;
        obs[1][15:13] = if3.valid_detail_out ? if3.detail_idx : 3'd0;
        obs[1][18:16] = if3.valid_coarse_out ? if3.coarse_wr_addr : 3'd0;
        obs[1][21:19] = if3.coarse_rd_en ? if3.coarse_rd_addr : 3'd0;
        obs[1][23:22] = if3.level;
        raw[1] = {if3.detail_idx, if3.coarse_wr_addr, if3.coarse_rd_addr};
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic        iv [0:MAXT];
    logic [31:0] exp_v [2][0:MAXT];
    int          done_t [2];
    int          replay_t0;

    task automatic chk(input string tag, input int t, input logic [31:0] observed,
                       input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, observed, expected);
    endtask

    // Expected timeline for a frame of a scheduler with nlev levels, from the
    // level-0 input pattern iv[]. Cycle 0 is the first LOAD cycle.
    task automatic build(input int d, input int nlev);
        int acc[$];
        int nxt[$];
        int len, seg, half, dt, last_c, r;
        for (int t = 0; t <= MAXT; t++) exp_v[d][t] = '0;
        for (int t = 0; t <= MAXT; t++) if (iv[t] && acc.size() < N) acc.push_back(t);
        for (int t = 0; t <= acc[N-1]; t++) exp_v[d][t][0] = 1'b1;
        len = N;
        seg = 0;
        for (int lv = 0; lv < nlev; lv++) begin
            half = len / 2;
            for (int k = 0; k < len; k += 2) exp_v[d][acc[k]][2:1] = 2'b11;
            for (int m = 0; m < half; m++) begin
                dt = (m < half - 1) ? acc[2*m+2] + 1 : acc[len-1] + 1;
                exp_v[d][dt][4:3]     = 2'b11;
                exp_v[d][dt][15:13]   = 3'(m);
                exp_v[d][dt+1][6:5]   = 2'b11;
                exp_v[d][dt+1][18:16] = 3'(m);
            end
            last_c = acc[len-1] + 2;
            if (lv < nlev - 1) begin
                r = last_c + 1;
                if (d == 0 && lv == 0) replay_t0 = r;
                nxt.delete();
                for (int i = 0; i < half; i++) begin
                    exp_v[d][r+i][7]     = 1'b1;
                    exp_v[d][r+i][21:19] = 3'(i);
                    exp_v[d][r+i+1][10]  = 1'b1;
                    nxt.push_back(r + i + 1);
                end
                for (int t = seg; t < r; t++) exp_v[d][t][23:22] = 2'(lv);
                seg = r;
                acc = nxt;
                len = half;
            end else begin
                done_t[d] = last_c + 1;
                for (int t = seg; t <= done_t[d]; t++) exp_v[d][t][23:22] = 2'(lv);
                exp_v[d][done_t[d]][12] = 1'b1;
            end
        end
        for (int t = 0; t <= done_t[d]; t++) begin
            exp_v[d][t][11] = 1'b1;
            exp_v[d][t][8]  = exp_v[d][t][22];
            exp_v[d][t][9]  = ~exp_v[d][t][22];
        end
    endtask

    task automatic reset_zero_checks(input string tag, input int t);
        chk({tag, "_l2"}, t, obs[0], 32'd0);
        chk({tag, "_l3"}, t, obs[1], 32'd0);
        chk({tag, "_raw_l2"}, t, {23'd0, raw[0]}, 32'd0);
        chk({tag, "_raw_l3"}, t, {23'd0, raw[1]}, 32'd0);
    endtask

    // mode 0: in_valid always high, 1: every other cycle, 2: random.
    // extra: pulse start while busy. abort_at>=0: assert reset at that cycle.
    task automatic run_frame(input int mode, input bit extra, input int abort_at,
                             input string name);
        int tend;
        int c0 = n_checks;
        int p0 = n_pass;
        for (int t = 0; t <= MAXT; t++) begin
            case (mode)
                0:       iv[t] = 1'b1;
                1:       iv[t] = (t % 2 == 0);
                default: iv[t] = (t >= 60) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
        end
        build(0, 2);
        build(1, 3);
        tend = done_t[1] + 2;

        @(posedge clk); #1;
        start_r    = 1'b1;
        in_valid_r = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_l2", -1, obs[0], 32'd0);
        chk("idle_l3", -1, obs[1], 32'd0);

        for (int t = 0; t <= tend; t++) begin
            @(posedge clk); #1;
            start_r = extra && ((t == replay_t0) ||
                      (t > 0 && t < done_t[0] && $urandom_range(0, 7) == 0));
            in_valid_r = iv[t];
            if (t == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset_zero_checks("abort_async", t);
                @(posedge clk); #1;
                reset_zero_checks("abort_held", t + 1);
                reset   = 1'b0;
                start_r = 1'b0;
                $display("frame %-14s aborted by reset at t=%0d checks=%0d passed=%0d",
                         name, t, n_checks - c0, n_pass - p0);
                return;
            end
            @(negedge clk);
            chk({name, "_l2"}, t, obs[0], exp_v[0][t]);
            chk({name, "_l3"}, t, obs[1], exp_v[1][t]);
        end
        start_r = 1'b0;
        $display("frame %-14s done_l2=c%0d done_l3=c%0d checks=%0d passed=%0d",
                 name, done_t[0], done_t[1], n_checks - c0, n_pass - p0);
    endtask

    initial begin
        reset      = 1'b1;
        start_r    = 1'b0;
        in_valid_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start_r    = 1'($urandom_range(0, 1));
            in_valid_r = 1'($urandom_range(0, 1));
            @(negedge clk);
            reset_zero_checks("reset", i);
        end
        @(posedge clk); #1;
        reset   = 1'b0;
        start_r = 1'b0;

        run_frame(0, 1'b0, -1, "full_rate");
        run_frame(1, 1'b0, -1, "half_rate");
        run_frame(0, 1'b0, 6,  "reset_mid");
        run_frame(0, 1'b0, -1, "after_reset");
        run_frame(0, 1'b1, -1, "start_busy");
        for (int f = 0; f < 4; f++) begin
            run_frame(2, 1'b1, -1, $sformatf("random_%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
